wide_add_ctrl: RTL

Multi-cycle controller that performs WORDS×32-bit additions by sequencing one shared 32-bit full adder (`fa_32`) one word per cycle, least-significant word first. The carry-out of each word is registered and fed back as the carry-in of the next. It sits between a requester with a start/done handshake and the existing `fa_32` datapath, so wide sums are computed without instantiating WORDS adders.

---
 rtl/wide_add_pkg.sv | 17 +
 rtl/fa_32.sv | 12 +
 rtl/wide_add_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the word-serial wide adder controller.
package wide_add_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Word-index width; a single-word build still needs a 1-bit counter.
   function automatic int clog2_min1(input int words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/fa_32.sv
// Existing 32-bit combinational full adder datapath.
module fa_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in,
   output logic [31:0] s,
   output logic        c_out
);

   assign {c_out, s} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};

endmodule

// File: rtl/wide_add_ctrl.sv
// Word-serial WORDS x 32-bit adder sequencing one shared fa_32, LSW first.
// Optional subtract mode with the `sub` port when WIDE_ADD_SUB_EN is defined.
module wide_add_ctrl
   import wide_add_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [WORD_W*WORDS-1:0]   a,
   input  logic [WORD_W*WORDS-1:0]   b,
   input  logic                      c_in,
`ifdef WIDE_ADD_SUB_EN
   input  logic                      sub,
`endif
   output logic                      busy,
   output logic                      done,
   output logic [WORD_W*WORDS-1:0]   s,
   output logic                      c_out
);

   localparam int W  = WORD_W * WORDS;
   localparam int IW = clog2_min1(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    s_q, s_d;
   logic            c_out_q, c_out_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            sub_sel;
   logic [WORD_W-1:0] fa_a, fa_b, fa_s;
   logic            fa_co;

`ifdef WIDE_ADD_SUB_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   assign fa_a = a_q[WORD_W*int'(idx_q) +: WORD_W];
   assign fa_b = b_q[WORD_W*int'(idx_q) +: WORD_W];

   fa_32 u_fa (
      .a     (fa_a),
      .b     (fa_b),
      .c_in  (carry_q),
      .s     (fa_s),
      .c_out (fa_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      c_out_d = c_out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               // Subtraction is a + ~b + 1, so the inverted operand and forced carry are latched here.
               a_d     = a;
               b_d     = sub_sel ? ~b : b;
               carry_d = sub_sel ? 1'b1 : c_in;
               s_d     = '0;
               c_out_d = 1'b0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[WORD_W*int'(idx_q) +: WORD_W] = fa_s;
            carry_d = fa_co;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            done_d  = 1'b1;
            c_out_d = carry_q;
            idx_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         c_out_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         c_out_q <= c_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Operand copies are only read in RUN, so they need no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign s     = s_q;
   assign c_out = c_out_q;

endmodule
